hack_rom_loader: RTL and testbench

//  Upstream stage of the Hack SOC: receives a framed program image as a byte stream
//  (from the UART receiver) and writes it word-by-word into instruction ROM.

---
 rtl/hack_rom_loader.sv | 168 ++++++++++++++++
 tb/tb_hack_rom_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: receives a framed program image byte stream and writes it into instruction ROM,
// holding the CPU in reset from frame start until the image checksum verifies.
module hack_rom_loader #(
  parameter int ADDR_W         = 15,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rom_we,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic [15:0]       o_rom_data,
  output logic              o_cpu_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [15:0]       o_words_loaded
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK} state_t;

  state_t              r_state, w_state;
  logic [15:0]         r_cnt, w_cnt;
  logic [7:0]          r_hi, w_hi;
  logic [ADDR_W-1:0]   r_idx, w_idx;
  logic [7:0]          r_chk, w_chk;
  logic [TW-1:0]       r_tmo, w_tmo;
  logic                r_we, w_we;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [15:0]         r_data, w_data;
  logic                r_cpu_reset, w_cpu_reset;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_error, w_error;
  logic [15:0]         r_words, w_words;
  logic [15:0]         w_cnt_full;
  logic                w_bad_cnt;
  logic                w_last;
  logic [7:0]          w_chk_in;

  assign w_cnt_full = {r_cnt[15:8], i_rx_data};
  assign w_bad_cnt  = (w_cnt_full == 16'd0) || ({1'b0, w_cnt_full} > DEPTH);
  assign w_last     = 17'(r_idx) == ({1'b0, r_cnt} - 17'd1);
  assign w_chk_in   = r_chk ^ i_rx_data;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_hi        = r_hi;
    w_idx       = r_idx;
    w_chk       = r_chk;
    w_tmo       = '0;
    w_we        = 1'b0;
    w_addr      = r_addr;
    w_data      = r_data;
    w_cpu_reset = r_cpu_reset;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_error     = r_error;
    w_words     = r_words;
    if (i_rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (i_rx_data == SYNC) begin
            w_state     = S_CNT_HI;
            w_cpu_reset = 1'b1;
            w_busy      = 1'b1;
            w_error     = 1'b0;
            w_words     = 16'd0;
            w_chk       = 8'd0;
            w_idx       = '0;
          end
        end
        S_CNT_HI: begin
          w_cnt   = {i_rx_data, r_cnt[7:0]};
          w_chk   = w_chk_in;
          w_state = S_CNT_LO;
        end
        S_CNT_LO: begin
          w_cnt   = w_cnt_full;
          w_chk   = w_chk_in;
          w_state = w_bad_cnt ? S_IDLE : S_DATA_HI;
          w_error = w_bad_cnt;
          w_busy  = !w_bad_cnt;
        end
        S_DATA_HI: begin
          w_hi    = i_rx_data;
          w_chk   = w_chk_in;
          w_state = S_DATA_LO;
        end
        S_DATA_LO: begin
          w_we    = 1'b1;
          w_addr  = r_idx;
          w_data  = {r_hi, i_rx_data};
          w_idx   = r_idx + 1'b1;
          w_words = r_words + 16'd1;
          w_chk   = w_chk_in;
          w_state = w_last ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: begin
          w_state     = S_IDLE;
          w_busy      = 1'b0;
          w_done      = i_rx_data == r_chk;
          w_error     = i_rx_data != r_chk;
          w_cpu_reset = i_rx_data != r_chk;
        end
        default: w_state = S_IDLE;
      endcase
    end else if (r_state != S_IDLE) begin
      // a stalled sender aborts the frame but leaves the CPU held in reset
      if (r_tmo == TMO_LAST) begin
        w_state = S_IDLE;
        w_error = 1'b1;
        w_busy  = 1'b0;
      end else begin
        w_tmo = r_tmo + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_idx       <= '0;
      r_chk       <= '0;
      r_tmo       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cpu_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_words     <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_hi        <= w_hi;
      r_idx       <= w_idx;
      r_chk       <= w_chk;
      r_tmo       <= w_tmo;
      r_we        <= w_we;
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_cpu_reset <= w_cpu_reset;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_error     <= w_error;
      r_words     <= w_words;
    end
  end

  assign o_rom_we       = r_we;
  assign o_rom_addr     = r_addr;
  assign o_rom_data     = r_data;
  assign o_cpu_reset    = r_cpu_reset;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_words;
endmodule

// File: tb/tb_hack_rom_loader.sv
// tb_hack_rom_loader: frame vectors plus timeout/reset sequences; ROM writes checked against a queue.
module tb_hack_rom_loader;
  localparam int ADDR_W = 15;
  localparam int TMO    = 16;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_rx_valid = 1'b0;
  logic [7:0]        i_rx_data = 8'd0;
  logic              o_rom_we;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [15:0]       o_rom_data;
  logic              o_cpu_reset;
  logic              o_busy;
  logic              o_done;
  logic              o_error;
  logic [15:0]       o_words_loaded;

  hack_rom_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_rom_we(o_rom_we), .o_rom_addr(o_rom_addr), .o_rom_data(o_rom_data),
    .o_cpu_reset(o_cpu_reset), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_words_loaded(o_words_loaded)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0]  n;
    logic [63:0] b;
    logic [1:0]  nw;
    logic [31:0] w;
    logic        err;
    logic        cpu;
    logic [15:0] words;
  } vec_t;

  vec_t tbl [7];
  logic [30:0] sb [$];
  int n_vec = 0;
  int n_bad = 0;
  int n_done = 0;
  int d0;
  int c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    d0 = n_done;
    for (int k = 0; k < int'(v.nw); k++)
      sb.push_back({15'(k), (k == 0) ? v.w[31:16] : v.w[15:0]});
    for (int k = 0; k < int'(v.n); k++) send(v.b[63-8*k -: 8]);
    idle(2);
    chk("error", 32'(o_error), 32'(v.err));
    chk("busy", 32'(o_busy), 0);
    chk("cpu_reset", 32'(o_cpu_reset), 32'(v.cpu));
    chk("words", 32'(o_words_loaded), 32'(v.words));
    chk("done_pulses", 32'(n_done - d0), 32'(!v.err));
    chk("sb_drained", 32'(sb.size()), 0);
  endtask

  always @(negedge i_clk) begin
    if (o_rom_we) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rom_write: got unexpected %0h@%0h expected none", o_rom_data, o_rom_addr);
      end else begin
        logic [30:0] e;
        e = sb.pop_front();
        if ({o_rom_addr, o_rom_data} !== e) begin
          n_bad++;
          $display("FAIL rom_write: got %0h@%0h expected %0h@%0h", o_rom_data, o_rom_addr, e[15:0], e[30:16]);
        end
      end
    end
    if (o_done) begin
      n_done++;
      n_vec++;
      if (o_cpu_reset || o_busy) begin
        n_bad++;
        $display("FAIL done_state: got cpu_reset=%0b busy=%0b expected 0 0", o_cpu_reset, o_busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'd8, 64'hA5_00_02_30_39_EC_10_F7, 2'd2, 32'h3039_EC10, 1'b0, 1'b0, 16'd2};
    tbl[1] = '{4'd8, 64'hA5_00_02_30_39_EC_10_00, 2'd2, 32'h3039_EC10, 1'b1, 1'b1, 16'd2};
    tbl[2] = '{4'd8, 64'hA5_00_02_30_39_EC_10_F7, 2'd2, 32'h3039_EC10, 1'b0, 1'b0, 16'd2};
    tbl[3] = '{4'd8, 64'h11_22_A5_00_01_A5_A5_01, 2'd1, 32'hA5A5_0000, 1'b0, 1'b0, 16'd1};
    tbl[4] = '{4'd3, 64'hA5_00_00_00_00_00_00_00, 2'd0, 32'h0,         1'b1, 1'b1, 16'd0};
    tbl[5] = '{4'd3, 64'hA5_80_01_00_00_00_00_00, 2'd0, 32'h0,         1'b1, 1'b1, 16'd0};
    tbl[6] = '{4'd6, 64'hA5_00_01_12_34_27_00_00, 2'd1, 32'h1234_0000, 1'b0, 1'b0, 16'd1};
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("rst_outputs", {o_rom_we, o_cpu_reset, o_busy, o_done, o_error}, 0);
    chk("rst_words", 32'(o_words_loaded), 0);
    chk("rst_addr_data", {o_rom_addr, o_rom_data}, 0);
    for (int i = 0; i < 7; i++) apply(tbl[i]);
    // idle timeout after one word
    sb.push_back({15'd0, 16'h1234});
    send(8'hA5); send(8'h00); send(8'h03); send(8'h12); send(8'h34);
    c = 0;
    for (int k = 0; k < 40; k++) begin
      idle(1);
      c++;
      if (c == 10) chk("tmo_early", {o_busy, o_error}, 32'b10);
      if (o_error) break;
    end
    chk("tmo_cycles", 32'(c), TMO);
    chk("tmo_flags", {o_error, o_busy, o_cpu_reset}, 32'b101);
    chk("tmo_words", 32'(o_words_loaded), 1);
    // sync byte clears error and starts a new frame
    send(8'hA5);
    chk("resync_flags", {o_error, o_busy, o_cpu_reset}, 32'b011);
    chk("resync_words", 32'(o_words_loaded), 0);
    sb.push_back({15'd0, 16'h1234});
    d0 = n_done;
    send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h27);
    idle(2);
    chk("resync_done", 32'(n_done - d0), 1);
    chk("resync_end", {o_error, o_busy, o_cpu_reset}, 0);
    // count of exactly 2**ADDR_W is legal
    send(8'hA5); send(8'h80); send(8'h00);
    idle(2);
    chk("full_cnt_ok", {o_busy, o_error}, 32'b10);
    for (int k = 0; k < 40 && !o_error; k++) idle(1);
    chk("full_cnt_tmo", {o_error, o_busy, o_cpu_reset}, 32'b101);
    // write timing, then reset mid-frame
    sb.push_back({15'd0, 16'hAABB});
    send(8'hA5); send(8'h00); send(8'h02); send(8'hAA); send(8'hBB);
    chk("we_timing", 32'(o_rom_we), 1);
    idle(1);
    chk("we_held_one", 32'(o_rom_we), 0);
    chk("mid_words", 32'(o_words_loaded), 1);
    send(8'hCC);
    i_reset = 1'b1;
    idle(1);
    i_reset = 1'b0;
    chk("midrst_outputs", {o_rom_we, o_cpu_reset, o_busy, o_done, o_error}, 0);
    chk("midrst_words", 32'(o_words_loaded), 0);
    apply(tbl[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
